// File: rtl/turn_signal_sequencer.sv
// Turn-signal lamp sequencer: left/right thermometer sweeps and hazard flash,
// paced by a free-running divider whose all-ones count acts as a clock enable.
module turn_signal_sequencer #(
    parameter int LAMPS     = 3,
    parameter int DIV_WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l,
    input  logic             r,
    input  logic             haz,
    output logic [LAMPS-1:0] left,
    output logic [LAMPS-1:0] right,
    output logic             tick,
    output logic             busy
);
    localparam int PW = $clog2(LAMPS + 1);
    localparam logic [PW-1:0] LAST = PW'(LAMPS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LEFT   = 2'd1;
    localparam logic [1:0] RIGHT  = 2'd2;
    localparam logic [1:0] HAZARD = 2'd3;

    logic [DIV_WIDTH-1:0] cnt;
    logic [1:0]           state;
    logic [PW-1:0]        phase;
    logic                 haz_req;

    assign tick    = &cnt;
    assign busy    = (state != IDLE);
    assign haz_req = haz | (l & r);

    function automatic logic [LAMPS-1:0] therm(input logic [PW-1:0] n);
        logic [LAMPS-1:0] t;
        for (int i = 0; i < LAMPS; i++) t[i] = (int'(n) > i);
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            state <= IDLE;
            phase <= '0;
            left  <= '0;
            right <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (haz_req) begin
                            state <= HAZARD;
                            left  <= '1;
                            right <= '1;
                        end else if (l) begin
                            state <= LEFT;
                            phase <= PW'(1);
                            left  <= therm(PW'(1));
                            right <= '0;
                        end else if (r) begin
                            state <= RIGHT;
                            phase <= PW'(1);
                            left  <= '0;
                            right <= therm(PW'(1));
                        end else begin
                            left  <= '0;
                            right <= '0;
                        end
                    end
                    LEFT, RIGHT: begin
                        // Only hazard can interrupt a sweep; l/r changes wait for IDLE.
                        if (haz) begin
                            state <= HAZARD;
                            phase <= '0;
                            left  <= '1;
                            right <= '1;
                        end else if (phase < LAST) begin
                            phase <= phase + 1'b1;
                            if (state == LEFT) left  <= therm(phase + 1'b1);
                            else               right <= therm(phase + 1'b1);
                        end else begin
                            state <= IDLE;
                            phase <= '0;
                            left  <= '0;
                            right <= '0;
                        end
                    end
                    HAZARD: begin
                        // Both banks move together, so bit 0 of left tells on/off.
                        if (left[0]) begin
                            left  <= '0;
                            right <= '0;
                        end else if (haz_req) begin
                            left  <= '1;
                            right <= '1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        phase <= '0;
                        left  <= '0;
                        right <= '0;
                    end
                endcase
            end
        end
    end
endmodule
